axis_mem_port_scheduler: RTL and testbench

Memory-side scheduler that shares one single-port synchronous RAM between the read-request stream and the write stream produced by the kernel-side handshake-to-AXI-Stream adapters. Each cycle it grants at most one single-beat request (read address or write address+data) to the RAM. It returns read data in request order on an AXI-Stream payload channel, with credit-based flow control so backpressure never drops data. Write-priority arbitration with a bounded write burst prevents read starvation.

---
 rtl/axis_mem_pkg.sv | 9 +
 rtl/axis_rsp_fifo.sv | 51 +++++
 rtl/axis_mem_port_scheduler.sv | 85 ++++++++
 tb/tb_axis_mem_port_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_mem_pkg.sv
// axis_mem_pkg: shared grant type and response-buffer sizing for the memory port scheduler.
package axis_mem_pkg;
    typedef enum logic [1:0] {GNT_NONE, GNT_RD, GNT_WR} grant_e;

    // One slot per read travelling through the RAM pipeline plus the one held at the payload port
    function automatic int rsp_depth(int rd_latency);
        return rd_latency + 1;
    endfunction
endpackage

// File: rtl/axis_rsp_fifo.sv
// axis_rsp_fifo: small synchronous FIFO for read responses; accepts a push into a full FIFO when it pops in the same cycle.
module axis_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= inc(wr_ptr);
            if (do_pop)
                rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/axis_mem_port_scheduler.sv
// axis_mem_port_scheduler: shares one single-port RAM between a read-request stream and a write stream,
// returning read data in order on a credit-protected payload stream with bounded write bursts.
module axis_mem_port_scheduler
    import axis_mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 2,
    parameter int DATA_WIDTH   = 64,
    parameter int RD_LATENCY   = 1,
    parameter int WR_BURST_MAX = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            s_axis_rd_tdata,
    input  logic                             s_axis_rd_tvalid,
    output logic                             s_axis_rd_tready,
    input  logic                             s_axis_rd_tlast,
    output logic [DATA_WIDTH-1:0]            m_axis_pl_tdata,
    output logic                             m_axis_pl_tvalid,
    input  logic                             m_axis_pl_tready,
    output logic                             m_axis_pl_tlast,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] s_axis_wr_tdata,
    input  logic                             s_axis_wr_tvalid,
    output logic                             s_axis_wr_tready,
    input  logic                             s_axis_wr_tlast,
    output logic                             mem_en,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic                             busy
);
    localparam int RSP_DEPTH = rsp_depth(RD_LATENCY);
    localparam int CW        = $clog2(RSP_DEPTH + 1);

    grant_e                gnt;
    logic [3:0]            wr_streak;
    logic [RD_LATENCY-1:0] rd_sr;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty, fifo_full, rd_elig, at_burst_max;
    logic                  unused_ok;

    assign unused_ok = s_axis_rd_tlast ^ s_axis_wr_tlast ^ fifo_full;

    // Every read already issued but not yet popped holds a response slot
    assign rd_elig      = s_axis_rd_tvalid && ($countones(rd_sr) + int'(fifo_count) < RSP_DEPTH);
    assign at_burst_max = wr_streak == 4'(WR_BURST_MAX);
    assign gnt          = !rst_n ? GNT_NONE :
                          (s_axis_wr_tvalid && !(at_burst_max && rd_elig)) ? GNT_WR :
                          rd_elig ? GNT_RD : GNT_NONE;

    assign s_axis_wr_tready = gnt == GNT_WR;
    assign s_axis_rd_tready = gnt == GNT_RD;
    assign mem_en           = gnt != GNT_NONE;
    assign mem_we           = gnt == GNT_WR;
    assign mem_addr         = gnt == GNT_WR ? s_axis_wr_tdata[DATA_WIDTH +: ADDR_WIDTH] :
                              gnt == GNT_RD ? s_axis_rd_tdata : '0;
    assign mem_wdata        = gnt == GNT_WR ? s_axis_wr_tdata[DATA_WIDTH-1:0] : '0;

    assign m_axis_pl_tvalid = !fifo_empty;
    assign m_axis_pl_tlast  = 1'b1;
    assign busy             = |rd_sr || !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_streak <= '0;
            rd_sr     <= '0;
        end else begin
            rd_sr     <= RD_LATENCY'({rd_sr, gnt == GNT_RD});
            wr_streak <= (!rd_elig || gnt == GNT_RD) ? '0 :
                         (gnt == GNT_WR && !at_burst_max) ? wr_streak + 4'd1 : wr_streak;
        end
    end

    axis_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(DATA_WIDTH)) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_sr[RD_LATENCY-1]),
        .din   (mem_rdata),
        .pop   (m_axis_pl_tvalid && m_axis_pl_tready),
        .dout  (m_axis_pl_tdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_axis_mem_port_scheduler.sv
// tb_axis_mem_port_scheduler: random and directed stimulus against a queue-based model of
// arbitration, read credits and in-order payload return.
module tb_axis_mem_port_scheduler;
    localparam int AW   = 4;
    localparam int DW   = 64;
    localparam int RL   = 2;
    localparam int BMAX = 4;
    localparam int RSP  = RL + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            rdy;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [AW-1:0]    s_axis_rd_tdata;
    logic             s_axis_rd_tvalid, s_axis_rd_tready, s_axis_rd_tlast;
    logic [DW-1:0]    m_axis_pl_tdata;
    logic             m_axis_pl_tvalid, m_axis_pl_tready, m_axis_pl_tlast;
    logic [AW+DW-1:0] s_axis_wr_tdata;
    logic             s_axis_wr_tvalid, s_axis_wr_tready, s_axis_wr_tlast;
    logic             mem_en, mem_we, busy;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata, mem_rdata;

    logic [DW-1:0] ram [1 << AW];
    logic [DW-1:0] rpipe [RL];
    logic [DW-1:0] model_mem [1 << AW];
    exp_t          q[$];
    int            n_err = 0, n_chk = 0;
    int            cyc = 0, streak = 0, rd_cnt = 0, idle_cnt = 0, pops = 0, seen_valid = 0;
    logic          chk_on = 1'b0, last_w = 1'b0, last_r = 1'b0;

    axis_mem_port_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RL), .WR_BURST_MAX(BMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_rd_tdata(s_axis_rd_tdata), .s_axis_rd_tvalid(s_axis_rd_tvalid),
        .s_axis_rd_tready(s_axis_rd_tready), .s_axis_rd_tlast(s_axis_rd_tlast),
        .m_axis_pl_tdata(m_axis_pl_tdata), .m_axis_pl_tvalid(m_axis_pl_tvalid),
        .m_axis_pl_tready(m_axis_pl_tready), .m_axis_pl_tlast(m_axis_pl_tlast),
        .s_axis_wr_tdata(s_axis_wr_tdata), .s_axis_wr_tvalid(s_axis_wr_tvalid),
        .s_axis_wr_tready(s_axis_wr_tready), .s_axis_wr_tlast(s_axis_wr_tlast),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-port RAM with RL-cycle read pipeline
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        rpipe[0] <= ram[mem_addr];
        for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[RL-1];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic          rd_elig, exp_w, exp_r, exp_v;
        logic [AW-1:0] exp_addr;
        if (!(rst_n && chk_on)) return;
        rd_elig  = s_axis_rd_tvalid && (q.size() < RSP);
        exp_w    = s_axis_wr_tvalid && !(streak == BMAX && rd_elig);
        exp_r    = !exp_w && rd_elig;
        exp_addr = exp_w ? s_axis_wr_tdata[DW+:AW] : exp_r ? s_axis_rd_tdata : '0;
        check("grant", 128'({s_axis_wr_tready, s_axis_rd_tready, mem_en, mem_we, mem_addr, mem_wdata}),
              128'({exp_w, exp_r, exp_w | exp_r, exp_w, exp_addr, exp_w ? s_axis_wr_tdata[DW-1:0] : 64'd0}));
        exp_v = q.size() > 0 && q[0].rdy <= cyc;
        check("pl_valid", 128'(m_axis_pl_tvalid), 128'(exp_v));
        check("busy", 128'(busy), 128'(q.size() > 0));
        if (m_axis_pl_tvalid) seen_valid++;
        if (exp_v) begin
            check("pl_data", 128'(m_axis_pl_tdata), 128'(q[0].data));
            check("pl_last", 128'(m_axis_pl_tlast), 128'(1'b1));
            if (m_axis_pl_tready) begin
                void'(q.pop_front());
                pops++;
            end
        end
        if (exp_r) begin
            q.push_back('{model_mem[s_axis_rd_tdata], cyc + RL + 1});
            rd_cnt++;
        end
        if (exp_w) model_mem[s_axis_wr_tdata[DW+:AW]] = s_axis_wr_tdata[DW-1:0];
        if (!(exp_w || exp_r)) idle_cnt++;
        streak = (!rd_elig || exp_r) ? 0 : (exp_w && streak < BMAX) ? streak + 1 : streak;
        last_w = s_axis_wr_tvalid && s_axis_wr_tready;
        last_r = s_axis_rd_tvalid && s_axis_rd_tready;
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic adv();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic tick();
        sample();
        adv();
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 128'({m_axis_pl_tvalid, m_axis_pl_tdata, m_axis_pl_tlast, mem_en, mem_we,
                         s_axis_rd_tready, s_axis_wr_tready, busy}),
              128'({1'b0, 64'd0, 1'b1, 5'd0}));
    endtask

    task automatic drain(input string tag);
        s_axis_rd_tvalid = 1'b0;
        s_axis_wr_tvalid = 1'b0;
        m_axis_pl_tready = 1'b1;
        for (int k = 0; k < 50 && q.size() > 0; k++) tick();
        repeat (2) tick();
        check(tag, 128'(q.size()), 128'(0));
    endtask

    initial begin
        int idx, base;
        rst_n = 1'b0;
        s_axis_rd_tdata = '0; s_axis_rd_tvalid = 1'b0; s_axis_rd_tlast = 1'b1;
        s_axis_wr_tdata = '0; s_axis_wr_tvalid = 1'b0; s_axis_wr_tlast = 1'b1;
        m_axis_pl_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        adv();
        chk_on = 1'b1;

        // Write 0xDEAD to address 2, read it back and time the payload
        m_axis_pl_tready = 1'b1;
        s_axis_wr_tvalid = 1'b1;
        s_axis_wr_tdata  = {4'd2, 64'hDEAD};
        tick();
        check("t0_write", 128'(last_w), 128'(1'b1));
        s_axis_wr_tvalid = 1'b0;
        s_axis_rd_tvalid = 1'b1;
        s_axis_rd_tdata  = 4'd2;
        tick();
        check("t1_read", 128'(last_r), 128'(1'b1));
        s_axis_rd_tvalid = 1'b0;
        tick();
        sample();
        check("lat_early", 128'(m_axis_pl_tvalid), 128'(1'b0));
        adv();
        sample();
        check("lat_valid", 128'({m_axis_pl_tvalid, m_axis_pl_tlast, m_axis_pl_tdata}), 128'({2'b11, 64'hDEAD}));
        adv();
        drain("drain_t1");

        // Preload every address with distinct data
        for (int a = 0; a < (1 << AW); a++) begin
            s_axis_wr_tvalid = 1'b1;
            s_axis_wr_tdata  = {AW'(a), $urandom, 28'($urandom), AW'(a)};
            tick();
        end
        s_axis_wr_tvalid = 1'b0;
        tick();

        // Both streams saturated: W,W,W,W,R with no idle cycle
        rd_cnt = 0;
        idle_cnt = 0;
        s_axis_wr_tvalid = 1'b1;
        s_axis_rd_tvalid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            s_axis_wr_tdata = {AW'($urandom), $urandom, $urandom};
            s_axis_rd_tdata = AW'($urandom);
            tick();
        end
        check("sat_idle", 128'(idle_cnt), 128'(0));
        check("sat_reads", 128'(rd_cnt), 128'(8));
        drain("drain_sat");

        // Backpressure: only RSP_DEPTH reads get credit, then all 8 return in order
        pops = 0;
        idx = 0;
        m_axis_pl_tready = 1'b0;
        s_axis_rd_tvalid = 1'b1;
        s_axis_rd_tdata  = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (last_r) idx++;
            s_axis_rd_tdata = AW'(idx);
        end
        check("bp_accept", 128'(idx), 128'(RSP));
        m_axis_pl_tready = 1'b1;
        for (int k = 0; k < 200 && idx < 8; k++) begin
            tick();
            if (last_r) idx++;
            s_axis_rd_tdata = AW'(idx);
        end
        check("bp_reads", 128'(idx), 128'(8));
        drain("bp_drain");
        check("bp_pops", 128'(pops), 128'(8));

        // Random traffic with random payload backpressure
        for (int k = 0; k < 800; k++) begin
            if (!s_axis_rd_tvalid || last_r) begin
                s_axis_rd_tvalid = 1'($urandom);
                s_axis_rd_tdata  = AW'($urandom);
            end
            if (!s_axis_wr_tvalid || last_w) begin
                s_axis_wr_tvalid = ($urandom % 3) == 0;
                s_axis_wr_tdata  = {AW'($urandom), $urandom, $urandom};
            end
            m_axis_pl_tready = ($urandom % 4) != 0;
            tick();
        end
        drain("drain_rand");

        // Reset with two reads in flight
        base = rd_cnt;
        m_axis_pl_tready = 1'b0;
        s_axis_rd_tvalid = 1'b1;
        s_axis_rd_tdata  = 4'd5;
        tick();
        s_axis_rd_tdata  = 4'd6;
        tick();
        s_axis_rd_tvalid = 1'b0;
        check("pre_rst_reads", 128'(rd_cnt - base), 128'(2));
        s_axis_wr_tvalid = 1'b1;
        s_axis_wr_tdata  = {4'd7, 64'h1234};
        #2;
        rst_n = 1'b0;
        chk_on = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        s_axis_wr_tvalid = 1'b0;
        q.delete();
        streak = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        adv();
        chk_on = 1'b1;
        seen_valid = 0;
        m_axis_pl_tready = 1'b1;
        repeat (10) tick();
        check("no_stale", 128'(seen_valid), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
